serial_shift_unit: RTL and testbench

- Iterative variable-amount shifter for the register-specified shift instructions (sllv/srlv/srav), with sll/srl/sra also routable through it.
- Shifts one bit position per clock under a start/done handshake.
- Replaces a wide barrel shifter in the execute path at the cost of multi-cycle latency.
- The control path stalls on busy until done.

---
 rtl/serial_shift_unit_if.sv | 33 +++
 rtl/serial_shift_unit.sv | 77 +++++++
 tb/tb_serial_shift_unit.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/serial_shift_unit_if.sv
// rtl/serial_shift_unit_if.sv - request/response bundle for the iterative shifter
interface serial_shift_unit_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               start;
    logic [1:0]         op;
    logic [WIDTH-1:0]   data_in;
    logic [SHAMT_W-1:0] shamt;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   result;

    modport master (
        output start,
        output op,
        output data_in,
        output shamt,
        input  busy,
        input  done,
        input  result
    );

    modport slave (
        input  start,
        input  op,
        input  data_in,
        input  shamt,
        output busy,
        output done,
        output result
    );
endinterface

// File: rtl/serial_shift_unit.sv
// rtl/serial_shift_unit.sv - one-bit-per-cycle sll/srl/sra shifter with start/done handshake
module serial_shift_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_shift_unit_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b11;

    state_t             state_q, state_d;
    logic [SHAMT_W-1:0] count_q, count_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   shifted;

    // Reserved op 2'b10 falls through to sll.
    always_comb begin
        unique case (op_q)
            OP_SRL:  shifted = {1'b0, result_q[WIDTH-1:1]};
            OP_SRA:  shifted = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
            default: shifted = {result_q[WIDTH-2:0], 1'b0};
        endcase
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        op_d     = op_q;
        result_d = result_q;
        unique case (state_q)
            ST_SHIFT: begin
                result_d = shifted;
                count_d  = count_q - 1'b1;
                if (count_q == SHAMT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                // IDLE and DONE both accept, which gives bubble-free back-to-back issue.
                state_d = ST_IDLE;
                if (bus.start) begin
                    result_d = bus.data_in;
                    op_d     = bus.op;
                    count_d  = bus.shamt;
                    state_d  = (bus.shamt != '0) ? ST_SHIFT : ST_DONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            op_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            op_q     <= op_d;
            result_q <= result_d;
        end
    end

    assign bus.busy   = (state_q == ST_SHIFT);
    assign bus.done   = (state_q == ST_DONE);
    assign bus.result = result_q;
endmodule

// File: tb/tb_serial_shift_unit.sv
// tb/tb_serial_shift_unit.sv - directed self-checking bench for serial_shift_unit
module tb_serial_shift_unit;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_shift_unit_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

    serial_shift_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Operands are scrambled right after the accept edge; the DUT must not see them.
    task automatic issue(input logic [1:0] op, input logic [31:0] data, input logic [4:0] sh);
        bus.start   = 1'b1;
        bus.op      = op;
        bus.data_in = data;
        bus.shamt   = sh;
        step();
        bus.start   = 1'b0;
        bus.op      = 2'b01;
        bus.data_in = 32'hA5A5_A5A5;
        bus.shamt   = 5'd7;
    endtask

    task automatic wait_done(output int cyc, output int busy_cyc);
        cyc      = 0;
        busy_cyc = 0;
        while (bus.done !== 1'b1 && cyc < 40) begin
            if (bus.busy === 1'b1) busy_cyc++;
            step();
            cyc++;
        end
    endtask

    task automatic run(input string tag, input logic [1:0] op, input logic [31:0] data,
                       input logic [4:0] sh, input logic [31:0] exp);
        int c, b;
        issue(op, data, sh);
        wait_done(c, b);
        check({tag, "_lat"}, c, 32'(sh));
        check({tag, "_busy"}, b, 32'(sh));
        check({tag, "_res"}, bus.result, exp);
        step();
        check({tag, "_pulse"}, {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        int c, b, n;
        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.data_in = '0;
        bus.shamt   = '0;
        rst_n       = 1'b0;
        repeat (3) step();
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_result", bus.result, 32'd0);
        rst_n = 1'b1;
        step();

        run("sll4", 2'b00, 32'h0000_0001, 5'd4, 32'h0000_0010);
        repeat (6) step();
        check("idle_hold", bus.result, 32'h0000_0010);

        run("sra31", 2'b11, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
        run("srl31", 2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001);
        run("srl0", 2'b01, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF);
        run("rsvd2", 2'b10, 32'h0000_0003, 5'd2, 32'h0000_000C);
        run("sra4pos", 2'b11, 32'h8765_4321, 5'd4, 32'hF876_5432);

        // start while busy is dropped, not queued
        issue(2'b00, 32'h0000_0001, 5'd8);
        step();
        bus.start   = 1'b1;
        bus.op      = 2'b11;
        bus.data_in = 32'hFFFF_FFFF;
        bus.shamt   = 5'd1;
        step();
        bus.start   = 1'b0;
        wait_done(c, b);
        check("ign_lat", 32'(c + 2), 32'd8);
        check("ign_res", bus.result, 32'h0000_0100);
        n = 0;
        repeat (12) begin
            step();
            if (bus.done === 1'b1) n++;
        end
        check("ign_extra_done", 32'(n), 32'd0);

        // back-to-back issue in the done cycle
        issue(2'b01, 32'h0000_00F0, 5'd4);
        wait_done(c, b);
        check("b2b1_lat", 32'(c), 32'd4);
        check("b2b1_res", bus.result, 32'h0000_000F);
        issue(2'b11, 32'hF000_0000, 5'd4);
        check("b2b_nobubble", {31'd0, bus.busy}, 32'd1);
        wait_done(c, b);
        check("b2b2_lat", 32'(c), 32'd4);
        check("b2b2_res", bus.result, 32'hFF00_0000);
        step();

        // asynchronous abort mid-shift
        issue(2'b00, 32'h0000_0ABC, 5'd20);
        repeat (5) step();
        check("abort_mid_res", bus.result, 32'h0001_5780);
        check("abort_mid_busy", {31'd0, bus.busy}, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        check("abort_res", bus.result, 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        n = 0;
        repeat (30) begin
            step();
            if (bus.done === 1'b1 || bus.busy === 1'b1) n++;
        end
        check("abort_no_done", 32'(n), 32'd0);
        run("post_rst", 2'b11, 32'h4000_0000, 5'd3, 32'h0800_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
